switch_event_detector: RTL and testbench

- Consumes the debounced switch level from `debounced` and classifies operator gestures into single-cycle event pulses: press, release, short press, long press and double press.
- Sits between `debounced` and the LED pattern logic (`shifter` or its successors) in the same `i_clock` domain, so downstream blocks get clean one-shot commands instead of a raw level.

---
 rtl/switch_event_detector_pkg.sv | 20 ++
 rtl/switch_event_detector_if.sv | 24 ++
 rtl/switch_event_detector_edge_detector.sv | 26 ++
 rtl/switch_event_detector.sv | 116 +++++++++++
 tb/tb_switch_event_detector.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/switch_event_detector_pkg.sv
// Shared definitions for the switch event detector: FSM state encoding and
// the timing-counter width helper.
package switch_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    // Counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int long_cycles, input int gap_cycles);
        int m;
        m = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/switch_event_detector_if.sv
// Switch level in, gesture event strobes out.
// Event outputs are one-cycle strobes with no ready/backpressure: the consumer
// must sample every cycle; i_switch is a level, not a handshake.
interface switch_event_detector_if;
    logic i_switch;
    logic o_press_pulse;
    logic o_release_pulse;
    logic o_short_pulse;
    logic o_long_pulse;
    logic o_double_pulse;
    logic o_held;

    modport master (
        output i_switch,
        input  o_press_pulse, o_release_pulse, o_short_pulse,
        input  o_long_pulse, o_double_pulse, o_held
    );

    modport slave (
        input  i_switch,
        output o_press_pulse, o_release_pulse, o_short_pulse,
        output o_long_pulse, o_double_pulse, o_held
    );
endinterface

// File: rtl/switch_event_detector_edge_detector.sv
// One-flop edge detector for an already-synchronous level; reusable for any
// switch input.
module edge_detector (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_level
);

    logic r_sw_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sw_q <= 1'b0;
        end else begin
            r_sw_q <= i_level;
        end
    end

    assign o_rise  = i_level & ~r_sw_q;
    assign o_fall  = ~i_level & r_sw_q;
    assign o_level = r_sw_q;

endmodule

// File: rtl/switch_event_detector.sv
// Classifies debounced switch activity into press, release, short, long and
// double one-cycle event pulses.
module switch_event_detector
    import switch_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int DOUBLE_GAP_CYCLES = 25000000
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    switch_event_detector_if.slave  ev,
    output state_t                  o_state
);

    localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

    logic             rise;
    logic             fall;
    logic             level;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             double_q;

    edge_detector u_edge (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_level   (ev.i_switch),
        .o_rise    (rise),
        .o_fall    (fall),
        .o_level   (level)
    );

    // Edge checks come first in each state so a coincident terminal count
    // loses: release beats long, second press beats short.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
        end else begin
            press_q   <= rise;
            release_q <= fall;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (fall) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_TERM) begin
                        state  <= LONG;
                        cnt    <= '0;
                        long_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                GAP: begin
                    if (rise) begin
                        state    <= PRESS2;
                        cnt      <= '0;
                        double_q <= 1'b1;
                    end else if (cnt == GAP_TERM) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        short_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ev.o_press_pulse   = press_q;
    assign ev.o_release_pulse = release_q;
    assign ev.o_short_pulse   = short_q;
    assign ev.o_long_pulse    = long_q;
    assign ev.o_double_pulse  = double_q;
    assign ev.o_held          = level;
    assign o_state            = state;

endmodule

// File: tb/tb_switch_event_detector.sv
// Directed bench for switch_event_detector with a cycle-stamped event scoreboard.
module tb_switch_event_detector;
  import switch_event_pkg::*;

  localparam int L = 8;
  localparam int G = 4;
  localparam int W = 21;  // {cycle[15:0], press, release, short, long, double}

  localparam logic [4:0] P_PRESS   = 5'b10000;
  localparam logic [4:0] P_RELEASE = 5'b01000;
  localparam logic [4:0] P_SHORT   = 5'b00100;
  localparam logic [4:0] P_LONG    = 5'b00010;
  localparam logic [4:0] P_DOUBLE  = 5'b00001;

  logic clk;
  logic rst_n;
  state_t dut_state;
  int unsigned cyc;
  int checks;
  int fails;
  logic [W-1:0] exp_q[$];

  switch_event_detector_if sif ();

  switch_event_detector #(
    .LONG_PRESS_CYCLES (L),
    .DOUBLE_GAP_CYCLES (G)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .ev        (sif),
    .o_state   (dut_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // monitor: pop and compare whenever any event pulse is presented
  always @(negedge clk) begin
    logic [4:0] pulses;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    pulses = {sif.o_press_pulse, sif.o_release_pulse, sif.o_short_pulse,
              sif.o_long_pulse, sif.o_double_pulse};
    if (pulses != 5'b0) begin
      got = {16'(cyc), pulses};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_event: got cyc=%0d pulses=%b, required no event", cyc, pulses);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails = fails + 1;
          $display("FAIL event: got cyc=%0d pulses=%b, required cyc=%0d pulses=%b",
                   got[W-1:5], got[4:0], exp[W-1:5], exp[4:0]);
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic drive(input logic v, input int n);
    sif.i_switch = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned c, input logic [4:0] p);
    exp_q.push_back({16'(c), p});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic check_quiet(input string name);
    check(name, {25'b0, sif.o_press_pulse, sif.o_release_pulse, sif.o_short_pulse,
                 sif.o_long_pulse, sif.o_double_pulse, sif.o_held, 1'b0}, 32'h0);
  endtask

  initial begin
    int unsigned c0;
    int unsigned c1;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    sif.i_switch = 1'b0;

    // reset with switch toggling: outputs stay low
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sif.i_switch = ~sif.i_switch;
      #1;
      check_quiet("reset_outputs");
      check("reset_state", 32'(dut_state), 32'(IDLE));
    end
    @(negedge clk);
    sif.i_switch = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 20);
    check("idle_state", 32'(dut_state), 32'(IDLE));

    // short press: high 3, short 4 after fall
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 4, P_RELEASE);
    push(c0 + 8, P_SHORT);
    drive(1'b1, 3);
    drive(1'b0, 12);

    // long press: high 12, long after E0+8, no short
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 9, P_LONG);
    push(c0 + 13, P_RELEASE);
    drive(1'b1, 10);
    check("held_level", 32'(sif.o_held), 32'd1);
    check("long_state", 32'(dut_state), 32'(LONG));
    drive(1'b1, 2);
    drive(1'b0, 15);

    // double press, gap of exactly G (rise on terminal edge)
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 3, P_RELEASE);
    push(c0 + 7, P_PRESS | P_DOUBLE);
    push(c0 + 9, P_RELEASE);
    drive(1'b1, 2);
    drive(1'b0, 4);
    drive(1'b1, 1);
    check("press2_state", 32'(dut_state), 32'(PRESS2));
    drive(1'b1, 1);
    drive(1'b0, 3);
    check("double_back_idle", 32'(dut_state), 32'(IDLE));
    drive(1'b0, 12);

    // double press with shorter gap
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 3, P_RELEASE);
    push(c0 + 6, P_PRESS | P_DOUBLE);
    push(c0 + 8, P_RELEASE);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 15);

    // gap of G+1: short, then a fresh first press
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 3, P_RELEASE);
    push(c0 + 7, P_SHORT);
    push(c0 + 8, P_PRESS);
    push(c0 + 10, P_RELEASE);
    push(c0 + 14, P_SHORT);
    drive(1'b1, 2);
    drive(1'b0, 5);
    drive(1'b1, 2);
    drive(1'b0, 15);

    // release on the 8th edge of a press: short, not long
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 9, P_RELEASE);
    push(c0 + 13, P_SHORT);
    drive(1'b1, 8);
    drive(1'b0, 15);

    // release one edge later: long, no short
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 9, P_LONG);
    push(c0 + 10, P_RELEASE);
    drive(1'b1, 9);
    drive(1'b0, 15);

    // reset two cycles into the gap, switch held across release
    c0 = cyc;
    push(c0 + 1, P_PRESS);
    push(c0 + 3, P_RELEASE);
    drive(1'b1, 2);
    drive(1'b0, 3);
    check("gap_state", 32'(dut_state), 32'(GAP));
    rst_n = 1'b0;
    sif.i_switch = 1'b1;
    #1;
    check_quiet("midreset_outputs");
    check("midreset_state", 32'(dut_state), 32'(IDLE));
    repeat (6) @(negedge clk);
    c1 = cyc;
    push(c1 + 1, P_PRESS);
    push(c1 + 3, P_RELEASE);
    push(c1 + 7, P_SHORT);
    rst_n = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 15);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
